// File: rtl/sfr_write_bank_pkg.sv
// Shared constants and helpers for the SFR write bank: addresses, status bit
// positions, reset values and the per-byte software update function.
package sfr_write_bank_pkg;

  localparam logic [7:0] ACC_ADDR  = 8'hE0;
  localparam logic [7:0] PSW_ADDR  = 8'hD0;
  localparam logic [7:0] IE_ADDR   = 8'hA8;
  localparam logic [7:0] SP_ADDR   = 8'h81;
  localparam logic [7:0] TMOD_ADDR = 8'h89;
  localparam logic [7:0] TL0_ADDR  = 8'h8A;
  localparam logic [7:0] TH0_ADDR  = 8'h8C;
  localparam logic [7:0] TCON_ADDR = 8'h88;
  localparam logic [7:0] SCON_ADDR = 8'h98;
  localparam logic [7:0] SBUF_ADDR = 8'h99;
  localparam logic [7:0] P2_ADDR   = 8'hA0;

  localparam int TF0_BIT = 5;
  localparam int TI_BIT  = 1;

  localparam logic [7:0] SP_RESET_VAL = 8'h07;
  localparam logic [7:0] P2_RESET_VAL = 8'hFF;

  localparam int NUM_SFR = 11;

  typedef enum logic [3:0] {
    IDX_ACC, IDX_PSW, IDX_IE, IDX_SP, IDX_TMOD, IDX_TL0,
    IDX_TH0, IDX_TCON, IDX_SCON, IDX_SBUF, IDX_P2
  } sfr_idx_e;

  function automatic logic [7:0] sfr_addr(input int idx);
    case (idx)
      int'(IDX_ACC):  return ACC_ADDR;
      int'(IDX_PSW):  return PSW_ADDR;
      int'(IDX_IE):   return IE_ADDR;
      int'(IDX_SP):   return SP_ADDR;
      int'(IDX_TMOD): return TMOD_ADDR;
      int'(IDX_TL0):  return TL0_ADDR;
      int'(IDX_TH0):  return TH0_ADDR;
      int'(IDX_TCON): return TCON_ADDR;
      int'(IDX_SCON): return SCON_ADDR;
      int'(IDX_SBUF): return SBUF_ADDR;
      default:        return P2_ADDR;
    endcase
  endfunction

  function automatic logic bit_addressable(input int idx);
    return (idx == int'(IDX_ACC))  || (idx == int'(IDX_PSW))  ||
           (idx == int'(IDX_IE))   || (idx == int'(IDX_TCON)) ||
           (idx == int'(IDX_SCON)) || (idx == int'(IDX_P2));
  endfunction

  // Byte write lands first, then a bit write overrides its single bit.
  function automatic logic [7:0] sw_update(
    input logic [7:0] cur,
    input logic       byte_wr,
    input logic [7:0] wdata,
    input logic       bit_wr,
    input logic [7:0] mask,
    input logic       val
  );
    logic [7:0] v;
    v = byte_wr ? wdata : cur;
    if (bit_wr) v = val ? (v | mask) : (v & ~mask);
    return v;
  endfunction

endpackage

// File: rtl/sfr_bit_decode.sv
// Maps a bit address onto a one-hot SFR byte select plus bit mask, and flags
// bit addresses that belong to internal RAM.
module sfr_bit_decode
  import sfr_write_bank_pkg::*;
(
  input  logic [7:0]         bit_addr,
  output logic [NUM_SFR-1:0] byte_sel,
  output logic [7:0]         bit_mask,
  output logic               ram_bit
);

  assign ram_bit  = ~bit_addr[7];
  assign bit_mask = 8'b1 << bit_addr[2:0];

  genvar gi;
  for (gi = 0; gi < NUM_SFR; gi++) begin : g_sel
    if (bit_addressable(gi)) begin : g_bitable
      assign byte_sel[gi] = bit_addr[7] & ({bit_addr[7:3], 3'b000} == sfr_addr(gi));
    end else begin : g_plain
      assign byte_sel[gi] = 1'b0;
    end
  end

endmodule

// File: rtl/sfr_write_bank.sv
// Physical SFR register bank: byte/bit writes, SP push/pop, timer/UART status
// events and RAM write forwarding. Optional stack guard: SFR_SP_GUARD_EN.
module sfr_write_bank
  import sfr_write_bank_pkg::*;
#(
  parameter logic [7:0] SP_RESET = SP_RESET_VAL,
  parameter logic [7:0] P2_RESET = P2_RESET_VAL
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_we,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wdata,
  input  logic       i_bit_we,
  input  logic [7:0] i_bit_addr,
  input  logic       i_bit_val,
  input  logic       i_sp_inc,
  input  logic       i_sp_dec,
  input  logic       i_tf0_set,
  input  logic       i_ti_set,
  output logic [7:0] o_acc,
  output logic [7:0] o_psw,
  output logic [7:0] o_ie,
  output logic [7:0] o_sp,
  output logic [7:0] o_tmod,
  output logic [7:0] o_th0,
  output logic [7:0] o_tl0,
  output logic [7:0] o_tcon,
  output logic [7:0] o_scon,
  output logic [7:0] o_sbuf,
  output logic [7:0] o_p2,
  output logic       o_ram_we,
  output logic [7:0] o_ram_addr,
  output logic [7:0] o_ram_wdata,
  output logic       o_ram_bit_we,
  output logic       o_tx_start,
  output logic       o_sp_err
);

  logic [NUM_SFR-1:0][7:0] sfr_reg;
  logic [NUM_SFR-1:0][7:0] sfr_next;
  logic [NUM_SFR-1:0]      byte_hit;
  logic [NUM_SFR-1:0]      bit_sel;
  logic [7:0]              bit_mask;
  logic                    bit_ram;
  logic [7:0]              acc_next;
  logic [7:0]              sp_sw;
  logic [7:0]              sp_next;
  logic                    byte_ram;
  logic                    bit_ram_wr;
  logic                    ram_we_reg;
  logic                    ram_bit_we_reg;
  logic                    tx_start_reg;
  logic [7:0]              ram_addr_reg;
  logic [7:0]              ram_wdata_reg;

  sfr_bit_decode u_bit_decode (
    .bit_addr (i_bit_addr),
    .byte_sel (bit_sel),
    .bit_mask (bit_mask),
    .ram_bit  (bit_ram)
  );

  // A byte RAM write owns the RAM port when both strobes target RAM at once.
  assign byte_ram   = i_we & ~i_addr[7];
  assign bit_ram_wr = i_bit_we & bit_ram & ~byte_ram;

  assign acc_next = sw_update(sfr_reg[IDX_ACC], byte_hit[IDX_ACC], i_wdata,
                              i_bit_we & bit_sel[IDX_ACC], bit_mask, i_bit_val);
  assign sp_sw    = sw_update(sfr_reg[IDX_SP], byte_hit[IDX_SP], i_wdata,
                              i_bit_we & bit_sel[IDX_SP], bit_mask, i_bit_val);

`ifdef SFR_SP_GUARD_EN
  logic sp_fault;
  logic sp_err_reg;
`endif

  always_comb begin
    sp_next = sp_sw;
`ifdef SFR_SP_GUARD_EN
    sp_fault = 1'b0;
`endif
    if (!byte_hit[IDX_SP]) begin
      if (i_sp_inc && !i_sp_dec) begin
`ifdef SFR_SP_GUARD_EN
        if (sfr_reg[IDX_SP] == 8'hFF) sp_fault = 1'b1;
        else sp_next = sfr_reg[IDX_SP] + 8'd1;
`else
        sp_next = sfr_reg[IDX_SP] + 8'd1;
`endif
      end else if (i_sp_dec && !i_sp_inc) begin
`ifdef SFR_SP_GUARD_EN
        if (sfr_reg[IDX_SP] == 8'h00) sp_fault = 1'b1;
        else sp_next = sfr_reg[IDX_SP] - 8'd1;
`else
        sp_next = sfr_reg[IDX_SP] - 8'd1;
`endif
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < NUM_SFR; gi++) begin : g_sfr
    assign byte_hit[gi] = i_we & (i_addr == sfr_addr(gi));
    if (gi == int'(IDX_ACC)) begin : g_acc
      assign sfr_next[gi] = acc_next;
    end else if (gi == int'(IDX_SP)) begin : g_sp
      assign sfr_next[gi] = sp_next;
    end else if (gi == int'(IDX_PSW)) begin : g_psw
      // Bit 0 is stored parity of the ACC value being registered alongside it.
      assign sfr_next[gi] = (sw_update(sfr_reg[gi], byte_hit[gi], i_wdata,
                                       i_bit_we & bit_sel[gi], bit_mask, i_bit_val)
                             & 8'hFE) | {7'b0, ^acc_next};
    end else if (gi == int'(IDX_TCON)) begin : g_tcon
      assign sfr_next[gi] = sw_update(sfr_reg[gi], byte_hit[gi], i_wdata,
                                      i_bit_we & bit_sel[gi], bit_mask, i_bit_val)
                            | ({7'b0, i_tf0_set} << TF0_BIT);
    end else if (gi == int'(IDX_SCON)) begin : g_scon
      assign sfr_next[gi] = sw_update(sfr_reg[gi], byte_hit[gi], i_wdata,
                                      i_bit_we & bit_sel[gi], bit_mask, i_bit_val)
                            | ({7'b0, i_ti_set} << TI_BIT);
    end else begin : g_plain
      assign sfr_next[gi] = sw_update(sfr_reg[gi], byte_hit[gi], i_wdata,
                                      i_bit_we & bit_sel[gi], bit_mask, i_bit_val);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sfr_reg          <= '0;
      sfr_reg[IDX_SP]  <= SP_RESET;
      sfr_reg[IDX_P2]  <= P2_RESET;
      ram_we_reg       <= 1'b0;
      ram_bit_we_reg   <= 1'b0;
      tx_start_reg     <= 1'b0;
      ram_addr_reg     <= 8'h00;
      ram_wdata_reg    <= 8'h00;
    end else begin
      sfr_reg        <= sfr_next;
      ram_we_reg     <= byte_ram;
      ram_bit_we_reg <= bit_ram_wr;
      tx_start_reg   <= byte_hit[IDX_SBUF];
      if (byte_ram) begin
        ram_addr_reg  <= i_addr;
        ram_wdata_reg <= i_wdata;
      end else if (bit_ram_wr) begin
        ram_addr_reg  <= i_bit_addr;
        ram_wdata_reg <= {7'b0, i_bit_val};
      end
    end
  end

`ifdef SFR_SP_GUARD_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) sp_err_reg <= 1'b0;
    else if (sp_fault) sp_err_reg <= 1'b1;
  end
  assign o_sp_err = sp_err_reg;
`else
  assign o_sp_err = 1'b0;
`endif

  assign o_acc        = sfr_reg[IDX_ACC];
  assign o_psw        = sfr_reg[IDX_PSW];
  assign o_ie         = sfr_reg[IDX_IE];
  assign o_sp         = sfr_reg[IDX_SP];
  assign o_tmod       = sfr_reg[IDX_TMOD];
  assign o_th0        = sfr_reg[IDX_TH0];
  assign o_tl0        = sfr_reg[IDX_TL0];
  assign o_tcon       = sfr_reg[IDX_TCON];
  assign o_scon       = sfr_reg[IDX_SCON];
  assign o_sbuf       = sfr_reg[IDX_SBUF];
  assign o_p2         = sfr_reg[IDX_P2];
  assign o_ram_we     = ram_we_reg;
  assign o_ram_bit_we = ram_bit_we_reg;
  assign o_ram_addr   = ram_addr_reg;
  assign o_ram_wdata  = ram_wdata_reg;
  assign o_tx_start   = tx_start_reg;

endmodule

// File: doc/sfr_write_bank.md
Name: sfr_write_bank

Overview:
- Write-side companion of the SFR read map. Owns the physical SFR registers: ACC, PSW, IE, SP, TMOD, TH0, TL0, TCON, SCON, SBUF and P2.
- Accepts byte writes, bit set/clear writes and SP push/pop from the control unit. Applies hardware status events from the timer and UART.
- Forwards every non-SFR write to internal RAM.
- Its register outputs feed the SFR read map and the peripherals.

Parameters:
- SP_RESET, 8'h07, reset value of SP
- P2_RESET, 8'hFF, reset value of P2

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  synchronous active-low reset
- i_we  input  1  byte write strobe
- i_addr  input  8  byte write direct address
- i_wdata  input  8  byte write data
- i_bit_we  input  1  bit write strobe
- i_bit_addr  input  8  bit address
- i_bit_val  input  1  bit value (1 = SETB, 0 = CLR)
- i_sp_inc  input  1  push: SP+1
- i_sp_dec  input  1  pop: SP-1
- i_tf0_set  input  1  timer0 overflow event (sets TCON[5])
- i_ti_set  input  1  UART transmit done event (sets SCON[1])
- o_acc, o_psw, o_ie, o_sp, o_tmod, o_th0, o_tl0, o_tcon, o_scon, o_sbuf, o_p2  output  8 each  register contents
- o_ram_we  output  1  registered RAM write strobe
- o_ram_addr  output  8  RAM address
- o_ram_wdata  output  8  RAM data
- o_ram_bit_we  output  1  registered RAM bit write strobe
- o_tx_start  output  1  one-cycle pulse after an SBUF write
- o_sp_err  output  1  sticky stack fault (optional feature only; 0 otherwise)

Behaviour:
- Reset, while i_rst_n=0 at a clock edge:
  - SP=SP_RESET, P2=P2_RESET.
  - All other registers 8'h00.
  - o_ram_we, o_ram_bit_we, o_tx_start and o_sp_err = 0.
  - Reset mid-operation discards in-flight strobes; no RAM write or tx pulse is issued after reset.
- SFR addresses: ACC E0, PSW D0, IE A8, SP 81, TMOD 89, TL0 8A, TH0 8C, TCON 88, SCON 98, SBUF 99, P2 A0.
- Byte write (i_we=1):
  - Address matches an SFR: that register takes i_wdata at the next edge.
  - Address ≥ 8'h80 but not listed: the write is dropped.
  - Address < 8'h80: o_ram_we=1, with o_ram_addr and o_ram_wdata registered. Latency 1 cycle.
- Bit write (i_bit_we=1):
  - i_bit_addr ≥ 8'h80: byte = {i_bit_addr[7:3],3'b000}, bit index = i_bit_addr[2:0].
  - Only ACC, PSW, IE, TCON, SCON and P2 are bit-addressable; others are ignored.
  - i_bit_addr < 8'h80: o_ram_bit_we=1 with o_ram_addr = i_bit_addr and o_ram_wdata[0] = i_bit_val, 1-cycle latency.
- PSW[0] is parity and is always ^ACC, taken from the registered ACC value. Writes to PSW[0] are ignored.
- SP handling:
  - i_sp_inc adds 1 and i_sp_dec subtracts 1, modulo 256.
  - inc and dec together: no change.
  - An explicit SP byte write in the same cycle wins over inc/dec.
- Hardware events:
  - i_tf0_set and i_ti_set win over a simultaneous software write or clear of the same bit; events are never lost.
  - The other bits of that byte still take the software value.
- SBUF write: o_tx_start pulses high for exactly 1 cycle on the cycle after the write, with o_sbuf already holding the new value. Back-to-back SBUF writes give back-to-back pulses.
- Simultaneous i_we and i_bit_we targeting the same SFR: the byte write is applied first, then the bit write overrides that single bit.

Optional Feature:
- Macro: SFR_SP_GUARD_EN.
- Defined:
  - i_sp_inc when SP=FF, or i_sp_dec when SP=00, leaves SP unchanged.
  - o_sp_err is set and stays sticky until reset.
- Undefined: SP wraps modulo 256 and o_sp_err is tied to 0.

Decomposition:
- Shared package/Defines.v holds:
  - SFR address constants (ACC_ADDR … P2_ADDR)
  - bit position constants TF0_BIT=5 and TI_BIT=1
  - reset-value constants
- One natural sub-module, sfr_bit_decode: combinationally maps a bit address to a byte-select one-hot plus a bit mask, with a RAM/not-bit-addressable indication.

Test Plan:
- Reset → SP=07, P2=FF, all other SFRs 00, o_sp_err=0, no strobes.
- Byte write E0←8'h07 → ACC=07, PSW[0]=1. Write PSW←8'h00 → PSW=8'h01 (parity bit retained).
- Bit write i_bit_addr=8'hA3, val=0 → P2=F7. Bit write addr 8'h2A → o_ram_bit_we=1 one cycle later, o_ram_addr=2A.
- Byte write 99←8'h55 → o_sbuf=55 and o_tx_start high for exactly 1 cycle. Same-cycle i_ti_set with SCON←8'h00 → SCON=8'h02.
- SP=FF with i_sp_inc:
  - Without macro → SP=00.
  - With SFR_SP_GUARD_EN → SP=FF and o_sp_err=1 until reset.
- i_sp_inc with a same-cycle SP←8'h30 → SP=30. Byte write 8'h40←8'hAB → o_ram_we, o_ram_addr=40, o_ram_wdata=AB one cycle later, with no SFR change.
